// File: rtl/vga_sync_decode.sv
// Receive-side VGA timing decoder: regenerates column/row from sampled active-low syncs,
// checks each line and frame against the configured mode and reports lock.
module vga_sync_decode #(
  parameter int unsigned H_VISIBLE     = 640,
  parameter int unsigned H_FRONT_PORCH = 16,
  parameter int unsigned H_SYNC_PULSE  = 96,
  parameter int unsigned H_BACK_PORCH  = 48,
  parameter int unsigned H_WHOLE_LINE  = 800,
  parameter int unsigned V_VISIBLE     = 480,
  parameter int unsigned V_FRONT_PORCH = 10,
  parameter int unsigned V_SYNC_PULSE  = 2,
  parameter int unsigned V_BACK_PORCH  = 33,
  parameter int unsigned V_WHOLE_FRAME = 525,
  parameter int unsigned LOCK_FRAMES   = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              hsync,
  input  logic                              vsync,
  output logic [$clog2(H_WHOLE_LINE)-1:0]   column,
  output logic [$clog2(V_WHOLE_FRAME)-1:0]  row,
  output logic                              visible,
  output logic                              locked,
  output logic                              sync_err
);

  localparam int unsigned COLUMN_BITS  = $clog2(H_WHOLE_LINE);
  localparam int unsigned ROW_BITS     = $clog2(V_WHOLE_FRAME);
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT_PORCH;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT_PORCH;
  localparam int unsigned GOOD_BITS    = $clog2(LOCK_FRAMES + 1);

  localparam logic [COLUMN_BITS-1:0] ColLast    = COLUMN_BITS'(H_WHOLE_LINE - 1);
  localparam logic [COLUMN_BITS-1:0] HSyncStart = COLUMN_BITS'(H_SYNC_START);
  localparam logic [COLUMN_BITS-1:0] HVisible   = COLUMN_BITS'(H_VISIBLE);
  localparam logic [ROW_BITS-1:0]    RowLast    = ROW_BITS'(V_WHOLE_FRAME - 1);
  localparam logic [ROW_BITS-1:0]    VSyncStart = ROW_BITS'(V_SYNC_START);
  localparam logic [ROW_BITS-1:0]    VVisible   = ROW_BITS'(V_VISIBLE);
  localparam logic [GOOD_BITS-1:0]   GoodLast   = GOOD_BITS'(LOCK_FRAMES - 1);

  // Catch inconsistent mode parameters at elaboration.
  if (H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH != H_WHOLE_LINE) begin : g_h_bad
    $error("horizontal timing parameters do not sum to H_WHOLE_LINE");
  end
  if (V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH != V_WHOLE_FRAME) begin : g_v_bad
    $error("vertical timing parameters do not sum to V_WHOLE_FRAME");
  end
  if (LOCK_FRAMES < 1) begin : g_lock_bad
    $error("LOCK_FRAMES must be at least 1");
  end

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e                  state_q, state_d;
  logic [GOOD_BITS-1:0]    good_q, good_d;
  logic                    clean_q, clean_d;
  logic                    hs_prev_q, vs_prev_q;
  logic [COLUMN_BITS-1:0]  column_q, column_d, pc;
  logic [ROW_BITS-1:0]     row_q, row_d, pr;
  logic                    visible_q, locked_q, sync_err_q;
  logic                    hs_fall, vs_fall, h_mis, v_mis, mis;

  always_comb begin
    pc = (column_q == ColLast) ? '0 : column_q + 1'b1;
    pr = row_q;
    if (pc == '0) begin
      pr = (row_q == RowLast) ? '0 : row_q + 1'b1;
    end
    hs_fall  = hs_prev_q & ~hsync;
    vs_fall  = vs_prev_q & ~vsync;
    // An edge where none is predicted, or no edge where one is, are both mismatches.
    h_mis    = hs_fall != (pc == HSyncStart);
    v_mis    = vs_fall != ((pc == '0) && (pr == VSyncStart));
    mis      = h_mis | v_mis;
    column_d = hs_fall ? HSyncStart : pc;
    row_d    = vs_fall ? VSyncStart : pr;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    clean_d = clean_q;
    unique case (state_q)
      StHunt: begin
        if (vs_fall) begin
          state_d = StVerify;
          good_d  = '0;
          clean_d = 1'b1;
        end
      end
      StVerify: begin
        if (vs_fall) begin
          clean_d = 1'b1;
          if (clean_q && !mis) begin
            good_d = good_q + 1'b1;
            if (good_q == GoodLast) begin
              state_d = StLocked;
            end
          end else begin
            good_d = '0;
          end
        end else if (mis) begin
          clean_d = 1'b0;
        end
      end
      StLocked: begin
        if (mis) begin
          state_d = StVerify;
          good_d  = '0;
          clean_d = 1'b0;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StHunt;
      good_q     <= '0;
      clean_q    <= 1'b0;
      hs_prev_q  <= 1'b1;
      vs_prev_q  <= 1'b1;
      column_q   <= '0;
      row_q      <= '0;
      visible_q  <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= enable & mis & (state_q != StHunt);
      if (enable) begin
        state_q   <= state_d;
        good_q    <= good_d;
        clean_q   <= clean_d;
        hs_prev_q <= hsync;
        vs_prev_q <= vsync;
        column_q  <= column_d;
        row_q     <= row_d;
        locked_q  <= (state_d == StLocked);
        visible_q <= (state_d == StLocked) && (column_d < HVisible) && (row_d < VVisible);
      end
    end
  end

  assign column   = column_q;
  assign row      = row_q;
  assign visible  = visible_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_vga_sync_decode.sv
// Self-checking bench for vga_sync_decode: a free-running 14x7 timing source feeds the decoder,
// expected coordinates are queued per sampled pixel and compared one clock later.
module tb_vga_sync_decode;

  typedef struct packed {
    logic [3:0] col;
    logic [2:0] row;
  } coord_t;

  logic       clk = 1'b0;
  logic       reset, enable, hsync, vsync;
  logic [3:0] column;
  logic [2:0] row;
  logic       visible, locked, sync_err;

  vga_sync_decode #(
    .H_VISIBLE    (8),
    .H_FRONT_PORCH(2),
    .H_SYNC_PULSE (2),
    .H_BACK_PORCH (2),
    .H_WHOLE_LINE (14),
    .V_VISIBLE    (4),
    .V_FRONT_PORCH(1),
    .V_SYNC_PULSE (1),
    .V_BACK_PORCH (1),
    .V_WHOLE_FRAME(7),
    .LOCK_FRAMES  (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .hsync   (hsync),
    .vsync   (vsync),
    .column  (column),
    .row     (row),
    .visible (visible),
    .locked  (locked),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  int     sx, sy, hlen, hstart, hkill_lines, last_sx;
  bit     track, hold_chk, have_exp;
  coord_t sb[$];
  coord_t last_exp;
  int     lock_cont, lock_gap, lock_re;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Source advances one pixel; a long line or killed hsync only lasts its own line(s).
  task automatic src_adv();
    if (sx == hlen - 1) begin
      sx     = 0;
      hlen   = 14;
      hstart = 10;
      if (hkill_lines > 0) hkill_lines--;
      sy = (sy == 6) ? 0 : sy + 1;
    end else begin
      sx++;
    end
  endtask

  task automatic tick(input bit en);
    coord_t c;
    enable = en;
    if (en) begin
      hsync = (hkill_lines > 0) || !(sx >= hstart && sx < hstart + 2);
      vsync = (sy != 5);
      if (track && hlen == 14) begin
        c.col = 4'(sx);
        c.row = 3'(sy);
        sb.push_back(c);
      end
    end
    @(posedge clk);
    #1;
    if (en) begin
      if (sb.size() > 0) begin
        c = sb.pop_front();
        check_eq("column", int'(column), int'(c.col));
        check_eq("row", int'(row), int'(c.row));
        last_exp = c;
        have_exp = 1'b1;
      end else begin
        have_exp = 1'b0;
      end
      last_sx = sx;
      src_adv();
    end else if (hold_chk && have_exp) begin
      check_eq("hold_column", int'(column), int'(last_exp.col));
      check_eq("hold_row", int'(row), int'(last_exp.row));
      check_eq("hold_sync_err", int'(sync_err), 0);
    end
  endtask

  task automatic run_to(input int x, input int y);
    int n = 0;
    while (!(sx == x && sy == y) && n < 200) begin
      tick(1'b1);
      n++;
    end
    check_eq("run_to_reached", int'(sx == x && sy == y), 1);
  endtask

  // Lock must appear right after the strobe that samples the third vsync fall.
  task automatic acquire(input string tag, input int period, output int lock_at);
    int strobes = 0;
    int vf = 0;
    int vf3 = -1;
    int errs = 0;
    bit en, is_vf;
    lock_at  = -1;
    track    = 1'b0;
    have_exp = 1'b0;
    sb.delete();
    for (int i = 0; i < period * 400 && lock_at < 0; i++) begin
      en    = (i % period) == 0;
      is_vf = en && sx == 0 && sy == 5;
      if (is_vf) begin
        vf++;
        track = 1'b1;
        if (vf == 3) vf3 = strobes;
      end
      tick(en);
      if (vf > 0) errs += int'(sync_err);
      if (en) begin
        if (locked) lock_at = strobes;
        strobes++;
      end
    end
    check_eq({tag, "_lock_strobe"}, lock_at, vf3);
    check_eq({tag, "_sync_err"}, errs, 0);
  endtask

  // Run a locked stream through a planted disturbance, then expect relock on the 3rd vsync fall.
  task automatic disturb(input string tag, input int exp_n, input int exp_last);
    int first_err = -1;
    int vfa = 0;
    int vf3 = -1;
    int relock = -1;
    int pos[$];
    bit was_locked, is_vf;
    track = 1'b1;
    for (int i = 0; i < 600 && relock < 0; i++) begin
      is_vf = sx == 0 && sy == 5;
      if (is_vf && first_err >= 0) begin
        vfa++;
        if (vfa == 3) vf3 = i;
      end
      was_locked = locked;
      tick(1'b1);
      if (sync_err) begin
        pos.push_back(last_sx);
        if (first_err < 0) begin
          first_err = i;
          check_eq({tag, "_drop"}, int'({was_locked, locked}), 2);
        end
      end
      if (first_err >= 0 && locked) relock = i;
    end
    check_eq({tag, "_err_count"}, pos.size(), exp_n);
    if (pos.size() > 0) begin
      check_eq({tag, "_first_err_pc"}, pos[0], 10);
      check_eq({tag, "_last_err_pc"}, pos[pos.size() - 1], exp_last);
    end
    check_eq({tag, "_relock"}, relock, vf3);
  endtask

  initial begin
    int vis, errs, unl;
    reset       = 1'b1;
    enable      = 1'b0;
    hsync       = 1'b1;
    vsync       = 1'b1;
    sx          = 3;
    sy          = 1;
    hlen        = 14;
    hstart      = 10;
    hkill_lines = 0;
    track       = 1'b0;
    hold_chk    = 1'b0;
    have_exp    = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_column", int'(column), 0);
    check_eq("rst_row", int'(row), 0);
    check_eq("rst_visible", int'(visible), 0);
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_sync_err", int'(sync_err), 0);
    reset = 1'b1;

    acquire("acq", 1, lock_cont);

    run_to(0, 0);
    vis  = 0;
    errs = 0;
    unl  = 0;
    for (int i = 0; i < 3 * 98; i++) begin
      tick(1'b1);
      vis  += int'(visible);
      errs += int'(sync_err);
      unl  += int'(!locked);
    end
    check_eq("track_visible", vis, 96);
    check_eq("track_sync_err", errs, 0);
    check_eq("track_unlocked", unl, 0);

    run_to(0, 0);
    hlen   = 15;
    hstart = 11;
    disturb("long", 2, 11);

    run_to(0, 0);
    hkill_lines = 3;
    disturb("nohs", 3, 10);

    run_to(5, 2);
    tick(1'b1);
    check_eq("pre_rst_visible", int'(visible), 1);
    check_eq("pre_rst_locked", int'(locked), 1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_column", int'(column), 0);
    check_eq("async_row", int'(row), 0);
    check_eq("async_visible", int'(visible), 0);
    check_eq("async_locked", int'(locked), 0);
    check_eq("async_sync_err", int'(sync_err), 0);
    #1 reset = 1'b1;
    acquire("reacq", 1, lock_re);

    reset  = 1'b0;
    enable = 1'b0;
    sx     = 3;
    sy     = 1;
    @(posedge clk);
    #1 reset = 1'b1;
    hold_chk = 1'b1;
    acquire("gap", 3, lock_gap);
    check_eq("gap_vs_cont_lock", lock_gap, lock_cont);
    for (int i = 0; i < 30; i++) begin
      tick((i % 3) == 0);
      check_eq("gap_locked", int'(locked), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
